// File: rtl/preemph.sv
// preemph: first-order fixed-point pre-emphasis filter for the FM transmit path.
//   y[n] = X0*x[n] + X1*x[n-1] + Y1*y[n-1], coefficients and samples in
//   Q(QUANT_BITS). Each sample takes four cycles: READ_X -> MUL -> ACC -> WRITE.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   x_in_rd_en    pop strobe to the input FIFO (combinational)
//   x_in_empty    input FIFO empty
//   x_in          input FIFO head (show-ahead, valid while !x_in_empty)
//   y_out         output sample, zero whenever y_out_wr_en is low
//   y_out_wr_en   push strobe to the output FIFO (combinational)
//   y_out_full    output FIFO full
//   sample_count  samples written since reset, wraps at 2^32
module preemph #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    QUANT_BITS = 10,
  parameter logic [DATA_WIDTH-1:0] X0_COEFF   = 32'h00000600,
  parameter logic [DATA_WIDTH-1:0] X1_COEFF   = 32'hfffffd66,
  parameter logic [DATA_WIDTH-1:0] Y1_COEFF   = 32'h00000000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         x_in_rd_en,
  input  logic                         x_in_empty,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_out_wr_en,
  input  logic                         y_out_full,
  output logic [31:0]                  sample_count
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] X0_S = X0_COEFF;
  localparam logic signed [DATA_WIDTH-1:0] X1_S = X1_COEFF;
  localparam logic signed [DATA_WIDTH-1:0] Y1_S = Y1_COEFF;

  typedef enum logic [1:0] {READ_X, MUL, ACC, WRITE} state_t;

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   x0_q, x0_d;
  logic signed [DATA_WIDTH-1:0]   x1_q, x1_d;
  logic signed [DATA_WIDTH-1:0]   y1_q, y1_d;
  logic signed [PW-1:0]           p0_q, p0_d;
  logic signed [PW-1:0]           p1_q, p1_d;
  logic signed [PW-1:0]           p2_q, p2_d;
  logic signed [DATA_WIDTH-1:0]   r_q, r_d;
  logic [31:0]                    cnt_q, cnt_d;

  // Divide by 2^QUANT_BITS rounding toward zero: negative products get a
  // bias of 2^QUANT_BITS-1 before the arithmetic shift, so -1536 -> -1
  // rather than -2. The result wraps to DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] bias;
    logic signed [PW-1:0] adj;
    bias                 = '0;
    bias[QUANT_BITS-1:0] = '1;
    adj                  = p[PW-1] ? (p + bias) : p;
    return DATA_WIDTH'(adj >>> QUANT_BITS);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= READ_X;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // Stage 0: pop a sample and shift the input history
      READ_X: begin
        if (x_in_rd_en) begin
          x1_d    = x0_q;
          x0_d    = x_in;
          state_d = MUL;
        end
      end
      // Stage 1: full-width signed products
      MUL: begin
        p0_d    = PW'(X0_S) * PW'(x0_q);
        p1_d    = PW'(X1_S) * PW'(x1_q);
        p2_d    = PW'(Y1_S) * PW'(y1_q);
        state_d = ACC;
      end
      // Stage 2: dequantise and sum with wraparound, feed result back
      ACC: begin
        r_d     = deq(p0_q) + deq(p1_q) + deq(p2_q);
        y1_d    = r_d;
        state_d = WRITE;
      end
      // Stage 3: push result, holding everything while the output is full
      WRITE: begin
        if (y_out_wr_en) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = READ_X;
        end
      end
      default: state_d = READ_X;
    endcase
  end

  // FIFO strobes are suppressed during reset so an in-flight sample is dropped.
  always_comb begin
    x_in_rd_en  = !rst && (state_q == READ_X) && !x_in_empty;
    y_out_wr_en = !rst && (state_q == WRITE) && !y_out_full;
    y_out       = y_out_wr_en ? r_q : '0;
  end

  assign sample_count = cnt_q;

endmodule
